// File: rtl/sram_like_bridge.sv
// CPU SRAM port to SRAM-like bus adapter. Each CPU access becomes one bus transaction, and a flush drops a response that is already in flight.
// Stall lasts at least one cycle and covers request, wait and orphan-drain time. DONE is held until longest_stall drops.
module sram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MODE   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sram_en,
  input  logic [DATA_W/8-1:0] sram_wen,
  input  logic [ADDR_W-1:0]   sram_addr,
  input  logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W-1:0]   sram_rdata,
  output logic                stall,
  input  logic                longest_stall,
  input  logic                flush,
  output logic                req,
  output logic                wr,
  output logic [2:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata
);

  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pend_wr_q, pend_wr_d;
  logic [2:0]        wr_size;
  logic [OFFW-1:0]   wr_off;
  logic              addr_lo_unused;

  assign addr_lo_unused = ^sram_addr[OFFW-1:0];

  // A store narrows only when its enables form one naturally aligned 2^k-byte run.
  always_comb begin
    wr_size = 3'(OFFW);
    wr_off  = '0;
    for (int k = 0; k <= OFFW; k++) begin
      for (int p = 0; p < NB; p++) begin
        if ((p % (1 << k)) == 0 && sram_wen == (NB'((1 << (1 << k)) - 1) << p)) begin
          wr_size = 3'(k);
          wr_off  = OFFW'(p);
        end
      end
    end
  end

  assign wr         = (MODE != 0) && (|sram_wen);
  assign size       = wr ? wr_size : 3'(OFFW);
  assign addr       = {sram_addr[ADDR_W-1:OFFW], (wr ? wr_off : {OFFW{1'b0}})};
  assign wdata      = sram_wdata;
  assign sram_rdata = rdata_q;
  assign stall      = ~rst & ((sram_en & (state_q != S_DONE)) | (state_q == S_DISCARD));

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    pend_wr_d = pend_wr_q;
    req       = 1'b0;
    case (state_q)
      S_IDLE: begin
        req = sram_en & ~flush & ~rst;
        if (req && addr_ok) begin
          pend_wr_d = wr;
          if (data_ok) begin
            state_d = S_DONE;
            if (!wr) rdata_d = rdata;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (data_ok) begin
          state_d = flush ? S_IDLE : S_DONE;
          if (!flush && !pend_wr_q) rdata_d = rdata;
        end else if (flush) begin
          state_d = S_DISCARD;
        end
      end
      S_DONE: begin
        if (!longest_stall || flush) state_d = S_IDLE;
      end
      S_DISCARD: begin
        if (data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rdata_q   <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      pend_wr_q <= pend_wr_d;
    end
  end

endmodule

// File: tb/tb_sram_like_bridge.sv
// Bench for sram_like_bridge: a 32-bit read-only port, a 32-bit read/write port and a 64-bit read/write port all share one stimulus stream.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        sram_en, lstall, flush, addr_ok, data_ok;
  logic [7:0]  wen;
  logic [31:0] saddr;
  logic [63:0] wdat, rdat;

  logic        rq0, st0, wr0, rq1, st1, wr1, rq2, st2, wr2;
  logic [2:0]  sz0, sz1, sz2;
  logic [31:0] ad0, ad1, ad2, rd0, rd1, wd0, wd1;
  logic [63:0] rd2, wd2;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  always #5 clk = ~clk;

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .MODE(0)) u_ro (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(wen[3:0]), .sram_addr(saddr),
    .sram_wdata(wdat[31:0]), .sram_rdata(rd0), .stall(st0), .longest_stall(lstall),
    .flush(flush), .req(rq0), .wr(wr0), .size(sz0), .addr(ad0), .wdata(wd0),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdat[31:0]));

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .MODE(1)) u_rw (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(wen[3:0]), .sram_addr(saddr),
    .sram_wdata(wdat[31:0]), .sram_rdata(rd1), .stall(st1), .longest_stall(lstall),
    .flush(flush), .req(rq1), .wr(wr1), .size(sz1), .addr(ad1), .wdata(wd1),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdat[31:0]));

  sram_like_bridge #(.ADDR_W(32), .DATA_W(64), .MODE(1)) u_w64 (
    .clk(clk), .rst(rst), .sram_en(sram_en), .sram_wen(wen), .sram_addr(saddr),
    .sram_wdata(wdat), .sram_rdata(rd2), .stall(st2), .longest_stall(lstall),
    .flush(flush), .req(rq2), .wr(wr2), .size(sz2), .addr(ad2), .wdata(wd2),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdat));

  typedef struct packed {
    logic        w;
    logic [2:0]  sz;
    logic [31:0] ad;
  } map_t;

  // Bus mapping for instance i, derived from the byte-enable population and lowest set lane.
  function automatic map_t mp(input int i);
    map_t m;
    int   nb, off, be, cnt, low;
    nb   = (i == 2) ? 8 : 4;
    off  = (i == 2) ? 3 : 2;
    be   = int'(wen) & ((1 << nb) - 1);
    m.w  = (i != 0) && (be != 0);
    m.sz = 3'(off);
    m.ad = saddr & ~((32'd1 << off) - 32'd1);
    if (m.w) begin
      cnt = $countones(be);
      low = 0;
      while (((be >> low) & 1) == 0) low++;
      if ((be >> low) == (1 << cnt) - 1 && (cnt & (cnt - 1)) == 0 && (low % cnt) == 0) begin
        m.sz = 3'($clog2(cnt));
        m.ad = m.ad | 32'(low);
      end
    end
    return m;
  endfunction

  function automatic logic [63:0] dmask(input int i);
    return (i == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Transaction-level model: pending response, completion held, orphan response, last read data.
  logic        m_busy, m_done, m_orph;
  logic        m_pw [3];
  logic [63:0] m_rd [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_orph <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_pw[i] <= 1'b0;
        m_rd[i] <= '0;
      end
    end else if (m_orph) begin
      if (data_ok) m_orph <= 1'b0;
    end else if (m_done) begin
      if (!lstall || flush) m_done <= 1'b0;
    end else if (m_busy) begin
      if (data_ok) begin
        m_busy <= 1'b0;
        if (!flush) begin
          m_done <= 1'b1;
          for (int i = 0; i < 3; i++) if (!m_pw[i]) m_rd[i] <= rdat & dmask(i);
        end
      end else if (flush) begin
        m_busy <= 1'b0;
        m_orph <= 1'b1;
      end
    end else if (sram_en && !flush && addr_ok) begin
      for (int i = 0; i < 3; i++) m_pw[i] <= mp(i).w;
      if (data_ok) begin
        m_done <= 1'b1;
        for (int i = 0; i < 3; i++) if (!mp(i).w) m_rd[i] <= rdat & dmask(i);
      end else begin
        m_busy <= 1'b1;
      end
    end
  end

  always @(posedge clk) if (rq1 && addr_ok) n_acc <= n_acc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic q, input logic st, input logic w,
                          input logic [2:0] sz, input logic [31:0] ad,
                          input logic [63:0] wd, input logic [63:0] rd);
    map_t m;
    logic er, es;
    m  = mp(i);
    er = !rst && sram_en && !flush && !m_busy && !m_done && !m_orph;
    es = !rst && ((sram_en && !m_done) || m_orph);
    chk($sformatf("u%0d req", i), q, er);
    chk($sformatf("u%0d stall", i), st, es);
    chk($sformatf("u%0d sram_rdata", i), rd, m_rd[i]);
    if (er) begin
      chk($sformatf("u%0d wr", i), w, m.w);
      chk($sformatf("u%0d size", i), sz, m.sz);
      chk($sformatf("u%0d addr", i), ad, m.ad);
      chk($sformatf("u%0d wdata", i), wd, wdat & dmask(i));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_inst(0, rq0, st0, wr0, sz0, ad0, {32'd0, wd0}, {32'd0, rd0});
    cmp_inst(1, rq1, st1, wr1, sz1, ad1, {32'd0, wd1}, {32'd0, rd1});
    cmp_inst(2, rq2, st2, wr2, sz2, ad2, wd2, rd2);
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic en, input logic [7:0] w, input logic [31:0] a,
                        input logic aok, input logic dok, input logic [63:0] rd,
                        input logic ls, input logic fl);
    sram_en = en; wen = w; saddr = a; addr_ok = aok; data_ok = dok;
    rdat = rd; lstall = ls; flush = fl;
  endtask

  logic [7:0]  s_wen [5] = '{8'h04, 8'h0C, 8'h06, 8'h0F, 8'h0A};
  logic [2:0]  s_sz  [5] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2};
  logic [31:0] s_ad  [5] = '{32'h22, 32'h22, 32'h20, 32'h20, 32'h20};

  initial begin
    rst  = 1'b1;
    wdat = 64'h0102_0304_0506_0708;
    set_in(0, 8'h00, 32'h0, 0, 0, 64'h0, 0, 0);
    @(posedge clk); #1;
    chk("reset req", rq1, 1'b0);
    chk("reset stall", st1, 1'b0);
    chk("reset rdata", rd2, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Read with addr_ok at cycle 2 and data_ok at cycle 4.
    set_in(1, 8'h00, 32'h1000_0006, 0, 0, 64'h0, 0, 0); #1;
    chk("rd req c0", rq1, 1'b1);
    chk("rd addr32", ad1, 32'h1000_0004);
    chk("rd size32", sz1, 3'd2);
    chk("rd addr64", ad2, 32'h1000_0000);
    chk("rd size64", sz2, 3'd3);
    tick();
    tick();
    addr_ok = 1'b1; #1; chk("rd req c2", rq1, 1'b1); tick();
    addr_ok = 1'b0; #1; chk("rd req c3", rq1, 1'b0); chk("rd stall c3", st1, 1'b1); tick();
    data_ok = 1'b1; rdat = 64'hCAFE_F00D_DEAD_BEEF; #1; chk("rd stall c4", st1, 1'b1); tick();
    data_ok = 1'b0; #1;
    chk("rd stall c5", st1, 1'b0);
    chk("rd data ro", rd0, 32'hDEAD_BEEF);
    chk("rd data rw", rd1, 32'hDEAD_BEEF);
    chk("rd data 64", rd2, 64'hCAFE_F00D_DEAD_BEEF);
    tick();
    sram_en = 1'b0; #1; chk("rd one request", n_acc, 1); tick();

    // Same-cycle completion held in DONE by longest_stall; stray data_ok ignored.
    set_in(1, 8'h00, 32'h40, 1, 1, 64'h3333_4444_1111_2222, 1, 0); #1;
    chk("sc req c0", rq1, 1'b1);
    tick();
    set_in(1, 8'h00, 32'h40, 0, 0, 64'h0, 1, 0); #1;
    chk("sc req hold", rq1, 1'b0);
    chk("sc stall hold", st1, 1'b0);
    chk("sc data", rd1, 32'h1111_2222);
    tick();
    data_ok = 1'b1; rdat = 64'hBAD0_BAD0_BAD0_BAD0; #1; chk("sc req c2", rq1, 1'b0); tick();
    data_ok = 1'b0; #1; chk("sc stray data_ok", rd1, 32'h1111_2222); tick();
    lstall = 1'b0; #1; chk("sc req c4", rq1, 1'b0); tick();
    #1; chk("sc idle again", rq1, 1'b1); chk("sc one request", n_acc, 2); tick();
    sram_en = 1'b0; tick();

    // Store byte-enable mapping at 0x20.
    for (int j = 0; j < 5; j++) begin
      set_in(1, s_wen[j], 32'h20, 1, 1, 64'h5555_5555_5555_5555, 0, 0); #1;
      chk($sformatf("st%0d wr", j), wr1, 1'b1);
      chk($sformatf("st%0d size", j), sz1, s_sz[j]);
      chk($sformatf("st%0d addr", j), ad1, s_ad[j]);
      chk($sformatf("st%0d ro wr", j), wr0, 1'b0);
      tick();
      set_in(0, 8'h00, 32'h0, 0, 0, 64'h0, 0, 0); #1;
      chk($sformatf("st%0d rdata kept", j), rd1, 32'h1111_2222);
      chk($sformatf("st%0d ro captured", j), rd0, 32'h5555_5555);
      tick();
    end

    // 64-bit port: upper-half word store, then an unaligned read.
    set_in(1, 8'hF0, 32'h100, 1, 1, 64'h7777_7777_7777_7777, 0, 0); #1;
    chk("w64 wr", wr2, 1'b1);
    chk("w64 size", sz2, 3'd2);
    chk("w64 addr", ad2, 32'h104);
    tick();
    set_in(0, 8'h00, 32'h0, 0, 0, 64'h0, 0, 0); tick();
    set_in(1, 8'h00, 32'h10F, 1, 1, 64'h0123_4567_89AB_CDEF, 0, 0); #1;
    chk("r64 size", sz2, 3'd3);
    chk("r64 addr", ad2, 32'h108);
    tick();
    set_in(0, 8'h00, 32'h0, 0, 0, 64'h0, 0, 0); #1;
    chk("r64 data", rd2, 64'h0123_4567_89AB_CDEF);
    tick();

    // Flush while waiting: the orphaned response must drain before a new request.
    set_in(1, 8'h00, 32'h80, 1, 0, 64'h0, 0, 0); #1; chk("fl req c0", rq1, 1'b1); tick();
    addr_ok = 1'b0; flush = 1'b1; #1; chk("fl stall c1", st1, 1'b1); tick();
    flush = 1'b0; saddr = 32'h200; #1;
    chk("fl stall c2", st1, 1'b1);
    chk("fl req c2", rq1, 1'b0);
    tick();
    data_ok = 1'b1; rdat = 64'h1234; #1;
    chk("fl stall c3", st1, 1'b1);
    chk("fl req c3", rq1, 1'b0);
    tick();
    data_ok = 1'b0; #1;
    chk("fl req c4", rq1, 1'b1);
    chk("fl addr c4", ad1, 32'h200);
    chk("fl rdata kept", rd1, 32'h89AB_CDEF);
    tick();
    sram_en = 1'b0; tick();

    // Asynchronous reset in the middle of WAIT.
    set_in(1, 8'h00, 32'h300, 1, 0, 64'h0, 0, 0); tick();
    addr_ok = 1'b0; #1; chk("ar stall before", st1, 1'b1);
    #1; rst = 1'b1; #1;
    chk("ar req", rq1, 1'b0);
    chk("ar stall", st1, 1'b0);
    chk("ar rdata", rd1, 32'h0);
    chk("ar stall 64", st2, 1'b0);
    tick();
    rst = 1'b0; sram_en = 1'b0; tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
